// File: rtl/axi_lite_req_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_req_arbiter
//
// Round-robin arbiter for NCH single-beat requesters in front of one
// AXI4-Lite master port. Each channel buffers one request (read or write).
// Transactions run one at a time. The originating channel gets a one-cycle
// completion pulse.
//
// Parameters
//   NCH     number of requester channels (1..8)
//   ADDR_W  address width
//   DATA_W  data width (32 or 64); strobe width is DATA_W/8
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid       per-channel one-cycle request pulse
//   req_mode        per-channel mode, 0 = read, 1 = write
//   req_addr        per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   req_wdata       per-channel write data, packed like req_addr
//   req_wstrb       per-channel byte strobes, packed like req_addr
//   req_busy        channel has a pending or in-flight request
//   resp_valid      one-cycle completion pulse per channel
//   resp_data       read data (0 for writes), valid with resp_valid
//   resp_err        SLVERR/DECERR flag, valid with resp_valid
//   axi_*           AXI4-Lite master AR/R/AW/W/B channels
// -----------------------------------------------------------------------------
module axi_lite_req_arbiter #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [NCH-1:0]               req_valid,
  input  logic [NCH-1:0]               req_mode,
  input  logic [NCH*ADDR_W-1:0]        req_addr,
  input  logic [NCH*DATA_W-1:0]        req_wdata,
  input  logic [NCH*(DATA_W/8)-1:0]    req_wstrb,
  output logic [NCH-1:0]               req_busy,
  output logic [NCH-1:0]               resp_valid,
  output logic [DATA_W-1:0]            resp_data,
  output logic                         resp_err,

  output logic [ADDR_W-1:0]            axi_araddr,
  output logic                         axi_arvalid,
  output logic [2:0]                   axi_arprot,
  input  logic                         axi_arready,

  input  logic [DATA_W-1:0]            axi_rdata,
  input  logic [1:0]                   axi_rresp,
  input  logic                         axi_rvalid,
  output logic                         axi_rready,

  output logic [ADDR_W-1:0]            axi_awaddr,
  output logic                         axi_awvalid,
  output logic [2:0]                   axi_awprot,
  input  logic                         axi_awready,

  output logic [DATA_W-1:0]            axi_wdata,
  output logic [DATA_W/8-1:0]          axi_wstrb,
  output logic                         axi_wvalid,
  input  logic                         axi_wready,

  input  logic [1:0]                   axi_bresp,
  input  logic                         axi_bvalid,
  output logic                         axi_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RADDR = 3'd1;
  localparam logic [2:0] RDATA = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] WRESP = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  // Per-channel request buffers
  logic [NCH-1:0]    pending;
  logic [NCH-1:0]    mode_q;
  logic [ADDR_W-1:0] addr_q  [NCH];
  logic [DATA_W-1:0] wdata_q [NCH];
  logic [STRB_W-1:0] wstrb_q [NCH];

  // Transaction engine
  logic [2:0]        state;
  logic [CW-1:0]     grant;
  logic [CW-1:0]     rr_ptr;
  logic              aw_pend;
  logic              w_pend;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Arbitration result
  logic              arb_found;
  logic [CW-1:0]     arb_idx;
  logic [CW-1:0]     scan_idx;

  // Response handshake that finishes the granted request
  logic              resp_hs;

  // Only the error bit of the response codes is used
  logic              unused_resp_lsb;
  assign unused_resp_lsb = axi_rresp[0] ^ axi_bresp[0];

  assign resp_hs = ((state == RDATA) && axi_rvalid) ||
                   ((state == WRESP) && axi_bvalid);

  // ---------------------------------------------------------------------------
  // Round-robin scan: first pending channel starting at rr_ptr, wrapping mod NCH
  // ---------------------------------------------------------------------------
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      scan_idx = CW'((32'(rr_ptr) + k) % NCH);
      if (!arb_found && pending[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture. A pulse on a channel that already holds a request is
  // dropped. Capture and clear never coincide on one channel: clear happens
  // only while pending is set, capture only while it is clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      mode_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        wstrb_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (req_valid[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          mode_q[i]  <= req_mode[i];
          addr_q[i]  <= req_addr[i*ADDR_W +: ADDR_W];
          wdata_q[i] <= req_wdata[i*DATA_W +: DATA_W];
          wstrb_q[i] <= req_wstrb[i*STRB_W +: STRB_W];
        end else if (resp_hs && (grant == CW'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM. AXI address/data registers load only in IDLE, so they
  // stay stable for the whole time their valid is raised.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      axi_araddr <= '0;
      axi_awaddr <= '0;
      axi_wdata  <= '0;
      axi_wstrb  <= '0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_idx;
            if (mode_q[arb_idx]) begin
              axi_awaddr <= addr_q[arb_idx];
              axi_wdata  <= wdata_q[arb_idx];
              axi_wstrb  <= wstrb_q[arb_idx];
              aw_pend    <= 1'b1;
              w_pend     <= 1'b1;
              state      <= WRITE;
            end else begin
              axi_araddr <= addr_q[arb_idx];
              state      <= RADDR;
            end
          end
        end

        RADDR: begin
          if (axi_arready) begin
            state <= RDATA;
          end
        end

        RDATA: begin
          if (axi_rvalid) begin
            rdata_q <= axi_rdata;
            err_q   <= axi_rresp[1];
            state   <= DONE;
          end
        end

        // AW and W retire independently; leave once neither is outstanding
        // after this cycle's handshakes.
        WRITE: begin
          if (aw_pend && axi_awready) begin
            aw_pend <= 1'b0;
          end
          if (w_pend && axi_wready) begin
            w_pend <= 1'b0;
          end
          if ((!aw_pend || axi_awready) && (!w_pend || axi_wready)) begin
            state <= WRESP;
          end
        end

        WRESP: begin
          if (axi_bvalid) begin
            rdata_q <= '0;
            err_q   <= axi_bresp[1];
            state   <= DONE;
          end
        end

        DONE: begin
          if (grant == CW'(NCH - 1)) begin
            rr_ptr <= '0;
          end else begin
            rr_ptr <= grant + 1'b1;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign axi_arvalid = (state == RADDR);
  assign axi_rready  = (state == RDATA);
  assign axi_awvalid = (state == WRITE) && aw_pend;
  assign axi_wvalid  = (state == WRITE) && w_pend;
  assign axi_bready  = (state == WRESP);
  assign axi_arprot  = 3'b000;
  assign axi_awprot  = 3'b000;

  assign req_busy  = pending;
  assign resp_data = (state == DONE) ? rdata_q : '0;
  assign resp_err  = (state == DONE) && err_q;

  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      resp_valid[i] = (state == DONE) && (grant == CW'(i));
    end
  end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_req_arbiter
//
// Directed bench for axi_lite_req_arbiter (NCH=4, DATA_W=64) with a small
// AXI4-Lite slave whose ready/valid latencies are set per test.
// -----------------------------------------------------------------------------
module tb_axi_lite_req_arbiter;

  localparam int NCH    = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NCH-1:0]            req_valid;
  logic [NCH-1:0]            req_mode;
  logic [NCH*ADDR_W-1:0]     req_addr;
  logic [NCH*DATA_W-1:0]     req_wdata;
  logic [NCH*STRB_W-1:0]     req_wstrb;
  logic [NCH-1:0]            req_busy;
  logic [NCH-1:0]            resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_err;
  logic [ADDR_W-1:0]         axi_araddr;
  logic                      axi_arvalid;
  logic [2:0]                axi_arprot;
  logic                      axi_arready;
  logic [DATA_W-1:0]         axi_rdata;
  logic [1:0]                axi_rresp;
  logic                      axi_rvalid;
  logic                      axi_rready;
  logic [ADDR_W-1:0]         axi_awaddr;
  logic                      axi_awvalid;
  logic [2:0]                axi_awprot;
  logic                      axi_awready;
  logic [DATA_W-1:0]         axi_wdata;
  logic [STRB_W-1:0]         axi_wstrb;
  logic                      axi_wvalid;
  logic                      axi_wready;
  logic [1:0]                axi_bresp;
  logic                      axi_bvalid;
  logic                      axi_bready;

  int n_checks = 0;
  int n_errors = 0;

  // Slave knobs
  int          ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  logic [63:0] r_data_val = '0;
  logic [1:0]  r_resp_val = '0;
  logic [1:0]  b_resp_val = '0;

  // Slave state
  int   ar_wait, aw_wait, w_wait, r_wait, b_wait;
  logic r_out, aw_done, w_done;

  always #5 clk = ~clk;

  axi_lite_req_arbiter #(
    .NCH    (NCH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_busy    (req_busy),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .axi_araddr  (axi_araddr),
    .axi_arvalid (axi_arvalid),
    .axi_arprot  (axi_arprot),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_awaddr  (axi_awaddr),
    .axi_awvalid (axi_awvalid),
    .axi_awprot  (axi_awprot),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready)
  );

  // ---------------------------------------------------------------------------
  // Slave model: each ready/valid rises after its programmed number of cycles
  // ---------------------------------------------------------------------------
  assign axi_arready = axi_arvalid && (ar_wait >= ar_dly);
  assign axi_awready = axi_awvalid && (aw_wait >= aw_dly);
  assign axi_wready  = axi_wvalid  && (w_wait  >= w_dly);
  assign axi_rvalid  = r_out && (r_wait >= r_dly);
  assign axi_rdata   = axi_rvalid ? r_data_val : '0;
  assign axi_rresp   = axi_rvalid ? r_resp_val : '0;
  assign axi_bvalid  = aw_done && w_done && (b_wait >= b_dly);
  assign axi_bresp   = axi_bvalid ? b_resp_val : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_wait <= 0; aw_wait <= 0; w_wait <= 0; r_wait <= 0; b_wait <= 0;
      r_out <= 1'b0; aw_done <= 1'b0; w_done <= 1'b0;
    end else begin
      ar_wait <= (axi_arvalid && !axi_arready) ? ar_wait + 1 : 0;
      aw_wait <= (axi_awvalid && !axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (axi_wvalid  && !axi_wready)  ? w_wait + 1  : 0;
      r_wait  <= (r_out && !(axi_rvalid && axi_rready)) ? r_wait + 1 : 0;
      b_wait  <= (aw_done && w_done && !(axi_bvalid && axi_bready)) ? b_wait + 1 : 0;
      if (axi_arvalid && axi_arready) r_out <= 1'b1;
      if (axi_rvalid && axi_rready)   r_out <= 1'b0;
      if (axi_awvalid && axi_awready) aw_done <= 1'b1;
      if (axi_wvalid && axi_wready)   w_done <= 1'b1;
      if (axi_bvalid && axi_bready) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; request pulses last one cycle.
  task automatic tick();
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic issue(input int ch, input logic mode, input logic [31:0] addr,
                       input logic [63:0] data, input logic [7:0] strb);
    req_valid[ch]                  = 1'b1;
    req_mode[ch]                   = mode;
    req_addr[ch*ADDR_W +: ADDR_W]  = addr;
    req_wdata[ch*DATA_W +: DATA_W] = data;
    req_wstrb[ch*STRB_W +: STRB_W] = strb;
  endtask

  // Wait (bounded) for the next completion pulse; n = cycles waited.
  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (resp_valid == '0 && n < 40);
    check("resp_seen", 64'(resp_valid != '0), 1);
  endtask

  int n;
  int extra;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_mode  = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    tick();
    tick();

    // Reset state
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy",       req_busy, 0);
    check("rst_arvalid",    axi_arvalid, 0);
    check("rst_awvalid",    axi_awvalid, 0);
    check("rst_wvalid",     axi_wvalid, 0);
    check("rst_readies",    {axi_rready, axi_bready}, 0);
    check("rst_araddr",     axi_araddr, 0);
    check("rst_resp_data",  resp_data, 0);

    rst = 1'b0;
    tick();

    // Fairness: all four read in the same cycle, each re-pulses in its DONE
    for (int c = 0; c < NCH; c++) issue(c, 1'b0, 32'h4000_0000 + 32'(c * 4), 0, 0);
    for (int k = 0; k < 8; k++) begin
      wait_resp(n);
      check("fair_grant",   resp_valid, 64'(4'b0001 << (k % 4)));
      check("fair_spacing", n, 4);
      if (k < 4) issue(k, 1'b0, 32'h4000_0000 + 32'(k * 4), 0, 0);
    end
    tick();
    check("fair_busy_idle", req_busy, 0);

    // Single read on ch0, zero-wait slave
    r_data_val = 64'hDEAD_BEEF;
    issue(0, 1'b0, 32'h8000_0000, 0, 0);
    tick();
    check("rd_c1_busy",    req_busy, 4'b0001);
    check("rd_c1_arvalid", axi_arvalid, 0);
    tick();
    check("rd_c2_arvalid", axi_arvalid, 1);
    check("rd_c2_araddr",  axi_araddr, 32'h8000_0000);
    check("rd_c2_arprot",  axi_arprot, 0);
    tick();
    check("rd_c3_rready",  axi_rready, 1);
    check("rd_c3_arvalid", axi_arvalid, 0);
    tick();
    check("rd_c4_resp_valid", resp_valid, 4'b0001);
    check("rd_c4_resp_data",  resp_data, 64'hDEAD_BEEF);
    check("rd_c4_resp_err",   resp_err, 0);
    check("rd_c4_busy",       req_busy, 0);
    tick();
    check("rd_c5_resp_valid", resp_valid, 0);

    // Write on ch1 with awready delayed 3 cycles, wready immediate
    aw_dly = 3;
    issue(1, 1'b1, 32'h1000_0010, 64'h1234_5678, 8'h03);
    tick();
    tick();
    check("wr_c2_awvalid", axi_awvalid, 1);
    check("wr_c2_wvalid",  axi_wvalid, 1);
    check("wr_c2_awaddr",  axi_awaddr, 32'h1000_0010);
    check("wr_c2_wdata",   axi_wdata, 64'h1234_5678);
    check("wr_c2_wstrb",   axi_wstrb, 8'h03);
    check("wr_c2_awprot",  axi_awprot, 0);
    tick();
    check("wr_c3_wvalid",  axi_wvalid, 0);
    check("wr_c3_awvalid", axi_awvalid, 1);
    tick();
    check("wr_c4_awvalid", axi_awvalid, 1);
    tick();
    check("wr_c5_awvalid", axi_awvalid, 1);
    check("wr_c5_awaddr",  axi_awaddr, 32'h1000_0010);
    tick();
    check("wr_c6_awvalid", axi_awvalid, 0);
    check("wr_c6_bready",  axi_bready, 1);
    tick();
    check("wr_c7_resp_valid", resp_valid, 4'b0010);
    check("wr_c7_resp_data",  resp_data, 0);
    check("wr_c7_resp_err",   resp_err, 0);
    aw_dly = 0;

    // Read error on ch0; re-pulses during RDATA and in the R handshake cycle drop
    r_dly      = 2;
    r_resp_val = 2'b10;
    r_data_val = 64'h55;
    tick();
    issue(0, 1'b0, 32'h0000_0100, 0, 0);
    tick();
    tick();
    tick();
    check("err_c3_rready", axi_rready, 1);
    issue(0, 1'b0, 32'h0000_0200, 0, 0);
    tick();
    tick();
    check("err_c5_r_handshake", 64'(axi_rvalid && axi_rready), 1);
    issue(0, 1'b0, 32'h0000_0300, 0, 0);
    tick();
    check("err_c6_resp_valid", resp_valid, 4'b0001);
    check("err_c6_resp_err",   resp_err, 1);
    check("err_c6_resp_data",  resp_data, 64'h55);
    extra = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (resp_valid != '0 || axi_arvalid) extra++;
    end
    check("err_no_second_resp", extra, 0);
    check("err_busy", req_busy, 0);
    r_dly      = 0;
    r_resp_val = 2'b00;

    // Reset during WRESP with ch1 write in flight and ch2 read pending
    b_dly = 5;
    issue(1, 1'b1, 32'h2000_0000, 64'hAA, 8'h0F);
    issue(2, 1'b0, 32'h2000_0040, 0, 0);
    tick();
    tick();
    tick();
    tick();
    check("rstmid_bready", axi_bready, 1);
    check("rstmid_busy",   req_busy, 4'b0110);
    rst = 1'b1;
    #1;
    check("rstmid_async_bready", axi_bready, 0);
    check("rstmid_async_busy",   req_busy, 0);
    check("rstmid_async_awaddr", axi_awaddr, 0);
    check("rstmid_async_wdata",  axi_wdata, 0);
    check("rstmid_async_wstrb",  axi_wstrb, 0);
    tick();
    tick();
    rst   = 1'b0;
    b_dly = 0;
    extra = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (resp_valid != '0 || axi_arvalid || axi_awvalid || req_busy != '0) extra++;
    end
    check("rstmid_quiet_after", extra, 0);

    // Round-robin pointer is back at 0: ch0 before ch3
    issue(3, 1'b0, 32'h0000_3000, 0, 0);
    issue(0, 1'b0, 32'h0000_0000, 0, 0);
    wait_resp(n);
    check("rstmid_first_grant", resp_valid, 4'b0001);
    wait_resp(n);
    check("rstmid_second_grant", resp_valid, 4'b1000);

    // 64-bit write on ch2 with wready delayed 2 cycles
    w_dly = 2;
    issue(2, 1'b1, 32'h3000_0008, 64'h0123_4567_89AB_CDEF, 8'hF0);
    tick();
    tick();
    check("w64_c2_awvalid", axi_awvalid, 1);
    check("w64_c2_wvalid",  axi_wvalid, 1);
    check("w64_c2_awaddr",  axi_awaddr, 32'h3000_0008);
    check("w64_c2_wdata",   axi_wdata, 64'h0123_4567_89AB_CDEF);
    check("w64_c2_wstrb",   axi_wstrb, 8'hF0);
    tick();
    check("w64_c3_awvalid", axi_awvalid, 0);
    check("w64_c3_wvalid",  axi_wvalid, 1);
    check("w64_c3_wdata",   axi_wdata, 64'h0123_4567_89AB_CDEF);
    tick();
    check("w64_c4_wvalid",  axi_wvalid, 1);
    wait_resp(n);
    check("w64_resp_valid", resp_valid, 4'b0100);
    check("w64_resp_data",  resp_data, 0);
    check("w64_resp_delay", n, 2);
    w_dly = 0;

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
